alu_pipe_hs: RTL and testbench
==============================

// Module: alu_pipe_hs
// PURPOSE
//  Parametrised, handshaked successor to the fixed 4-bit registered ALU datapath.
//  Two-stage pipeline: stage 1 registers operands and opcode, stage 2 registers
//  the ALU result plus flags. Both ports use valid/ready flow control, so the
//  block can stall, and it counts completed results. Sits between the input
//  pad/sync logic and the output pads in the power-aware example tops.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
//  CNT_W  8  width of completed-transaction counter
// PORTS
//  clk       in   1      rising-edge clock, single domain
//  reset     in   1      synchronous, active-low reset
//  in_valid  in   1      operand set on in1/in2/sel is valid
//  in_ready  out  1      block accepts operands this cycle
//  in1       in   WIDTH  operand A (unsigned)
//  in2       in   WIDTH  operand B (unsigned)
//  sel       in   2      opcode: 00 ADD, 01 SUB (in1-in2), 10 AND, 11 XOR
//  out_valid out  1      result on out1/out_cy/out_zero is valid
//  out_ready in   1      downstream accepts result this cycle
//  out1      out  WIDTH  result
//  out_cy    out  1      ADD carry-out / SUB borrow (in1<in2); 0 for AND/XOR
//  out_zero  out  1      1 when out1 == 0
//  op_count  out  CNT_W  number of results consumed (out_valid & out_ready)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): s1_valid, out_valid=0; out1, out_cy=0;
//    out_zero=1; op_count=0. Reset mid-operation flushes both stages and drops
//    in-flight data with no partial output.
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//  - Stage 2 advances when (!out_valid || out_ready).
//    Stage 1 advances when (!s1_valid || stage2 advances).
//    in_ready = !s1_valid || stage2 advances. The ready path is combinational
//    from out_ready; there is no bubble, so throughput is 1 result per cycle.
//  - Latency: operands accepted at edge N appear on out1 with out_valid=1 after
//    edge N+1, when downstream is ready.
//  - Stall: while out_valid && !out_ready, out1/out_cy/out_zero hold stable;
//    stage 1 holds its operands. in_ready=0 once both stages are full.
//  - Simultaneous transfer in and out in the same cycle: both occur; occupancy
//    is unchanged.
//  - in_valid without in_ready: input is ignored. The source holds its data;
//    the block does not capture it.
//  - Arithmetic: unsigned, computed at WIDTH+1 bits. out1 = low WIDTH bits.
//    ADD wraps (e.g. WIDTH=4: F+1 -> 0, cy=1). SUB wraps (0-1 -> F, cy=1).
//  - op_count increments on each output transfer and wraps from 2^CNT_W-1 to 0.
//  - A sel value is sampled with its operands. Changing sel while stalled has no
//    effect on already-captured data.
// CONFIGURATION
//  ALU_PIPE_SAT_EN defined: ADD saturates to all-ones on carry, and SUB clamps
//    to 0 on borrow. out_cy still reports the overflow. out_zero reflects the
//    saturated value.
//  Not defined: ADD/SUB wrap modulo 2^WIDTH as described above.
//  AND/XOR are unaffected in both builds.
// TESTING
//  1 Reset: hold reset=0 3 cycles with in_valid=1 -> out_valid=0, out1=0,
//    out_zero=1, op_count=0, no capture after release.
//  2 Streaming, out_ready=1, WIDTH=4: ADD 3+4, SUB 9-2, AND C&A, XOR C^A on
//    consecutive cycles -> 7,7,8,6 on consecutive cycles, 2 cycles after
//    issue; op_count=4.
//  3 Overflow, WIDTH=4: ADD F+1 -> out1=0, cy=1, zero=1 (SAT_EN: out1=F,
//    cy=1, zero=0). SUB 0-1 -> out1=F, cy=1 (SAT_EN: out1=0, cy=1, zero=1).
//  4 Backpressure: out_ready=0 for 5 cycles while issuing 3 ops -> 2 accepted,
//    in_ready=0, out1 stable. Release -> results in order, none lost/duplicated.
//  5 Reset mid-stream with both stages full -> next cycle out_valid=0,
//    op_count=0; the first post-reset op returns the correct result.
//  6 CNT_W=8: 256 transfers -> op_count wraps to 0.
//    Random valid/ready at WIDTH=16 -> output matches scoreboard.

Source files
------------

// File: rtl/alu_pipe_hs_if.sv
// Operand/result handshake bundle for alu_pipe_hs.
// Latency: none; wires only.
// Backpressure: in_ready/out_ready carry the stall in both directions.
// Ports (slave = ALU side):
//   in_valid, in_ready, in1, in2, sel        operand channel
//   out_valid, out_ready, out1, out_cy, out_zero   result channel
interface alu_pipe_hs_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic             out_cy;
  logic             out_zero;

  modport master (
    output in_valid, in1, in2, sel, out_ready,
    input  in_ready, out_valid, out1, out_cy, out_zero
  );

  modport slave (
    input  in_valid, in1, in2, sel, out_ready,
    output in_ready, out_valid, out1, out_cy, out_zero
  );
endinterface

// File: rtl/alu_pipe_hs.sv
// Two-stage handshaked ALU (ADD/SUB/AND/XOR) with completed-result counter.
// Latency: operands accepted at edge N are presented on out1 after edge N+1.
// Backpressure: in_ready is combinational from out_ready; full rate, no bubble.
// Ports: clk, reset (sync, active-low), bus (alu_pipe_hs_if.slave),
//        op_count (results consumed, wraps at 2^CNT_W).
// Build option: define ALU_PIPE_SAT_EN to saturate ADD to all-ones on carry and
//   clamp SUB to zero on borrow; without it ADD/SUB wrap modulo 2^WIDTH.
module alu_pipe_hs #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_pipe_hs_if.slave     bus,
  output logic [CNT_W-1:0] op_count
);

`ifdef ALU_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
  } s1_t;

  logic             s1_valid;
  s1_t              s1_q;
  logic             s2_adv;
  logic             s1_adv;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;

  // Stage 2 frees up whenever its result leaves (or it is empty); stage 1 may
  // refill in the same cycle, which is what keeps throughput at one per cycle.
  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  // Stage 1: operands and opcode are captured together, so a later change on
  // sel never affects data already inside the pipe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q <= '{a: bus.in1, b: bus.in2, op: bus.sel};
      end
    end
  end

  // One extra bit on ADD/SUB exposes carry-out and borrow directly.
  always_comb begin
    sum     = {1'b0, s1_q.a} + {1'b0, s1_q.b};
    diff    = {1'b0, s1_q.a} - {1'b0, s1_q.b};
    alu_res = '0;
    alu_cy  = 1'b0;
    case (op_e'(s1_q.op))
      OP_ADD: begin
        alu_cy  = sum[WIDTH];
        alu_res = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        alu_cy  = diff[WIDTH];
        alu_res = (SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      end
      OP_AND:  alu_res = s1_q.a & s1_q.b;
      OP_XOR:  alu_res = s1_q.a ^ s1_q.b;
      default: alu_res = '0;
    endcase
  end

  // Stage 2: result registers hold while stalled downstream.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out1      <= '0;
      bus.out_cy    <= 1'b0;
      bus.out_zero  <= 1'b1;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out1     <= alu_res;
        bus.out_cy   <= alu_cy;
        bus.out_zero <= (alu_res == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_count <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
module tb_alu_pipe_hs;
  localparam int CNT_W = 8;

`ifdef ALU_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  alu_pipe_hs_if #(.WIDTH(4))  b4 ();
  alu_pipe_hs_if #(.WIDTH(16)) b16 ();
  logic [CNT_W-1:0] cnt4;
  logic [CNT_W-1:0] cnt16;

  alu_pipe_hs #(.WIDTH(4), .CNT_W(CNT_W)) dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave), .op_count(cnt4));
  alu_pipe_hs #(.WIDTH(16), .CNT_W(CNT_W)) dut16 (
    .clk(clk), .reset(reset), .bus(b16.slave), .op_count(cnt16));

  // Channel 0 = WIDTH 4 instance, channel 1 = WIDTH 16 instance.
  logic        d_vld[2];
  logic [15:0] d_a[2];
  logic [15:0] d_b[2];
  logic [1:0]  d_sel[2];
  logic        d_ordy[2];

  assign b4.in_valid   = d_vld[0];
  assign b4.in1        = d_a[0][3:0];
  assign b4.in2        = d_b[0][3:0];
  assign b4.sel        = d_sel[0];
  assign b4.out_ready  = d_ordy[0];
  assign b16.in_valid  = d_vld[1];
  assign b16.in1       = d_a[1];
  assign b16.in2       = d_b[1];
  assign b16.sel       = d_sel[1];
  assign b16.out_ready = d_ordy[1];

  logic        m_irdy[2];
  logic        m_ovld[2];
  logic        m_cy[2];
  logic        m_z[2];
  logic [15:0] m_out[2];
  logic [7:0]  m_cnt[2];

  assign m_irdy[0] = b4.in_ready;
  assign m_ovld[0] = b4.out_valid;
  assign m_cy[0]   = b4.out_cy;
  assign m_z[0]    = b4.out_zero;
  assign m_out[0]  = {12'd0, b4.out1};
  assign m_cnt[0]  = cnt4;
  assign m_irdy[1] = b16.in_ready;
  assign m_ovld[1] = b16.out_valid;
  assign m_cy[1]   = b16.out_cy;
  assign m_z[1]    = b16.out_zero;
  assign m_out[1]  = b16.out1;
  assign m_cnt[1]  = cnt16;

  typedef struct {
    logic [15:0] r;
    logic        cy;
    logic        z;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] r;
    logic        cy;
    logic        z;
    int          acc;
    int          done;
  } log_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   last_rst = 1'b1;
  exp_t q[2][$];
  log_t lg[$];
  int   cnt_m[2];
  bit   in_f[2];
  bit   out_f[2];
  logic [15:0] cap_a[2];
  logic [15:0] cap_b[2];
  logic [1:0]  cap_s[2];
  logic [15:0] cap_out[2];
  logic        cap_cy[2];
  logic        cap_z[2];

  function automatic int wid(int k);
    return (k == 0) ? 4 : 16;
  endfunction

  // Reference: plain integer arithmetic on the masked operands.
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b,
                                 logic [1:0] s, int acc);
    longint m = (longint'(1) << w) - 1;
    longint x = longint'(a) & m;
    longint y = longint'(b) & m;
    longint r;
    exp_t e;
    e.cy = 1'b0;
    case (s)
      2'd0: begin
        r = x + y;
        e.cy = (r > m);
        r = r & m;
        if (SAT && e.cy) r = m;
      end
      2'd1: begin
        e.cy = (x < y);
        r = (x - y) & m;
        if (SAT && e.cy) r = 0;
      end
      2'd2: r = x & y;
      default: r = x ^ y;
    endcase
    e.r   = r[15:0];
    e.z   = (r == 0);
    e.acc = acc;
    return e;
  endfunction

  function automatic void chk(string nm, longint act, longint exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endfunction

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit    ev;
      string p;
      p = $sformatf("w%0d ", wid(k));
      in_f[k]    = d_vld[k] && m_irdy[k];
      out_f[k]   = m_ovld[k] && d_ordy[k];
      cap_a[k]   = d_a[k];
      cap_b[k]   = d_b[k];
      cap_s[k]   = d_sel[k];
      cap_out[k] = m_out[k];
      cap_cy[k]  = m_cy[k];
      cap_z[k]   = m_z[k];
      if (last_rst) begin
        chk({p, "rst out_valid"}, m_ovld[k], 0);
        chk({p, "rst out1"}, m_out[k], 0);
        chk({p, "rst out_cy"}, m_cy[k], 0);
        chk({p, "rst out_zero"}, m_z[k], 1);
        chk({p, "rst op_count"}, m_cnt[k], 0);
        chk({p, "rst in_ready"}, m_irdy[k], 1);
      end else begin
        ev = (q[k].size() > 0) && (cyc >= q[k][0].acc + 1);
        chk({p, "out_valid"}, m_ovld[k], ev);
        chk({p, "in_ready"}, m_irdy[k], (q[k].size() < 2) || d_ordy[k]);
        chk({p, "op_count"}, m_cnt[k], cnt_m[k]);
        if (ev && m_ovld[k]) begin
          chk({p, "out1"}, m_out[k], q[k][0].r);
          chk({p, "out_cy"}, m_cy[k], q[k][0].cy);
          chk({p, "out_zero"}, m_z[k], q[k][0].z);
        end
      end
    end
  end

  // Model update at the active edge, using values captured at the falling edge.
  always @(posedge clk) begin
    cyc++;
    last_rst = !reset;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        q[k].delete();
        cnt_m[k] = 0;
      end else begin
        if (out_f[k] && q[k].size() > 0) begin
          if (k == 0) lg.push_back('{cap_out[0], cap_cy[0], cap_z[0], q[0][0].acc, cyc});
          void'(q[k].pop_front());
          cnt_m[k] = (cnt_m[k] + 1) % 256;
        end
        if (in_f[k]) q[k].push_back(model(wid(k), cap_a[k], cap_b[k], cap_s[k], cyc));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int k, logic [15:0] a, logic [15:0] b, logic [1:0] s);
    int t = 0;
    bit ok;
    d_vld[k] = 1'b1;
    d_a[k]   = a;
    d_b[k]   = b;
    d_sel[k] = s;
    do begin
      @(posedge clk);
      t++;
    end while (!in_f[k] && t < 100);
    ok = in_f[k];
    #1;
    d_vld[k] = 1'b0;
    if (!ok) fail_now("send accept");
  endtask

  task automatic chk_log(string nm, int idx, int r, int cy);
    if (idx < lg.size()) begin
      chk({nm, " out1"}, lg[idx].r, r);
      chk({nm, " cy"}, lg[idx].cy, cy);
      chk({nm, " zero"}, lg[idx].z, (r == 0) ? 1 : 0);
    end else begin
      fail_now({nm, " missing result"});
    end
  endtask

  bit rdone = 1'b0;

  initial begin
    int base;
    int t;
    logic [15:0] hold;
    int e2[4] = '{7, 7, 8, 6};
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_vld[k] = 1'b0; d_a[k] = '0; d_b[k] = '0; d_sel[k] = '0; d_ordy[k] = 1'b1;
    end

    // Reset held with a valid operand present: nothing may be captured.
    d_vld[0] = 1'b1; d_a[0] = 16'd5; d_b[0] = 16'd3;
    tick(3);
    chk("t1 out_valid", m_ovld[0], 0);
    chk("t1 out_zero", m_z[0], 1);
    reset = 1'b1;
    d_vld[0] = 1'b0;
    tick(3);
    chk("t1 no capture", m_ovld[0], 0);
    chk("t1 op_count", m_cnt[0], 0);
    chk("t1 log empty", lg.size(), 0);

    // Streaming at full rate.
    base = lg.size();
    send(0, 3, 4, 2'd0);
    send(0, 9, 2, 2'd1);
    send(0, 12, 10, 2'd2);
    send(0, 12, 10, 2'd3);
    tick(3);
    chk("t2 results", lg.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk_log($sformatf("t2 op%0d", i), base + i, e2[i], 0);
      if (base + i < lg.size()) chk("t2 latency", lg[base + i].done - lg[base + i].acc, 2);
    end
    chk("t2 op_count", m_cnt[0], 4);

    // Overflow corners.
    base = lg.size();
    send(0, 15, 1, 2'd0);
    send(0, 0, 1, 2'd1);
    tick(3);
    chk_log("t3 add F+1", base, SAT ? 15 : 0, 1);
    chk_log("t3 sub 0-1", base + 1, SAT ? 0 : 15, 1);

    // Backpressure: two fill the pipe, the third waits.
    base = lg.size();
    d_ordy[0] = 1'b0;
    send(0, 1, 2, 2'd0);
    send(0, 8, 3, 2'd1);
    d_vld[0] = 1'b1; d_a[0] = 16'd5; d_b[0] = 16'd3; d_sel[0] = 2'd3;
    tick(1);
    hold = m_out[0];
    tick(5);
    chk("t4 in_ready", m_irdy[0], 0);
    chk("t4 out1 stable", m_out[0], hold);
    chk("t4 out1 head", m_out[0], 3);
    chk("t4 none consumed", lg.size() - base, 0);
    d_ordy[0] = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (!in_f[0] && t < 20);
    if (!in_f[0]) fail_now("t4 third accept");
    #1;
    d_vld[0] = 1'b0;
    tick(4);
    chk("t4 results", lg.size() - base, 3);
    chk_log("t4 op0", base, 3, 0);
    chk_log("t4 op1", base + 1, 5, 0);
    chk_log("t4 op2", base + 2, 6, 0);

    // Reset with both stages full.
    d_ordy[0] = 1'b0;
    send(0, 4, 4, 2'd0);
    send(0, 6, 6, 2'd3);
    tick(1);
    chk("t5 full in_ready", m_irdy[0], 0);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("t5 out_valid", m_ovld[0], 0);
    chk("t5 op_count", m_cnt[0], 0);
    d_ordy[0] = 1'b1;
    base = lg.size();
    send(0, 2, 5, 2'd0);
    tick(3);
    chk("t5 results", lg.size() - base, 1);
    chk_log("t5 first op", base, 7, 0);

    // 256 transfers wrap the counter back to zero.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    base = lg.size();
    for (int i = 0; i < 256; i++) send(0, 16'($urandom), 16'($urandom), 2'($urandom));
    tick(3);
    chk("t6 transfers", lg.size() - base, 256);
    chk("t6 op_count wrap", m_cnt[0], 0);

    // Random valid/ready on the 16-bit instance.
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          int gap;
          logic [15:0] a;
          gap = $urandom_range(0, 2);
          if (gap != 0) tick(gap);
          a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
          send(1, a, 16'($urandom), 2'($urandom));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          d_ordy[1] = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
    join
    d_ordy[1] = 1'b1;
    t = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) fail_now("drain");
    chk("rand op_count", m_cnt[1], cnt_m[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    fail_now("global watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
